// File: rtl/status_init_ctrl_pkg.sv
// Shared parameters for the status array front-end controller: row geometry,
// FSM encodings and the derived row count.
package status_init_ctrl_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int ROW_WIDTH  = 8;
    localparam int NUM_BLOCKS = 8;
    localparam int NUM_ROWS   = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Last row of the sweep; reaching it ends INIT.
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);

endpackage

// File: rtl/status_init_ctrl.sv
// status_init_ctrl: sits in front of the status array read/write ports.
// After reset it sweeps every row with all-zero data and a full mask, holding
// off fetch reads and fill writes; afterwards it forwards both and refuses a
// read that collides with a same-row write in the same cycle.
// Optional build macro STATUS_FLUSH_EN adds i_flush, which restarts the sweep
// from RUN.
module status_init_ctrl
    import status_init_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH = 1
) (
    input  logic                  gated_clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    input  logic [ADDR_WIDTH-1:0] i_r_addr,
    input  logic                  i_r_valid,
    output logic                  o_r_ready,
    input  logic [ADDR_WIDTH-1:0] i_w_addr,
    input  logic [ROW_WIDTH-1:0]  i_w_data,
    input  logic [NUM_BLOCKS-1:0] i_w_wmask,
    input  logic                  i_w_valid,
    output logic                  o_w_ready,
`ifdef STATUS_FLUSH_EN
    input  logic                  i_flush,
`endif
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic [ADDR_WIDTH-1:0] o_r_addr,
    output logic                  o_r_valid,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [ROW_WIDTH-1:0]  o_w_data,
    output logic [NUM_BLOCKS-1:0] o_w_wmask,
    output logic                  o_w_valid,
    output logic                  o_init_done
);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic                    conflict;
    logic                    r_ready;
    logic                    r_valid;
    logic                    flush_req;

`ifdef STATUS_FLUSH_EN
    assign flush_req = i_flush;
`else
    assign flush_req = 1'b0;
`endif

    // State and sweep counter; asynchronous reset restarts the sweep at row 0.
    always_ff @(posedge gated_clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: sweep advances only when not halted; flush re-enters INIT.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!i_halt) begin
            case (state)
                ST_INIT: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_ROW) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush_req) begin
                        state_nxt = ST_INIT;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Read path decode: a same-row write wins, the read is refused this cycle.
    always_comb begin
        conflict = i_w_valid & i_r_valid & (i_w_addr == i_r_addr);
        r_ready  = (state == ST_RUN) & ~i_halt & ~conflict;
        r_valid  = i_r_valid & r_ready;
    end

    // Output decode: INIT drives the sweep write, RUN passes requests through.
    always_comb begin
        o_r_addr    = i_r_addr;
        o_r_ready   = r_ready;
        o_r_valid   = r_valid;
        o_tag       = i_tag & {TAG_WIDTH{r_valid}};
        o_w_ready   = 1'b0;
        o_w_valid   = 1'b0;
        o_w_addr    = cnt;
        o_w_data    = '0;
        o_w_wmask   = '1;
        o_init_done = 1'b0;
        if (state == ST_RUN) begin
            o_w_ready   = ~i_halt;
            o_w_valid   = i_w_valid & ~i_halt;
            o_w_addr    = i_w_addr;
            o_w_data    = i_w_data;
            o_w_wmask   = i_w_wmask;
            o_init_done = 1'b1;
        end else begin
            o_w_valid   = ~i_halt;
        end
    end

endmodule

// File: tb/tb_status_init_ctrl.sv
// Testbench for status_init_ctrl: directed scenarios plus random traffic,
// checked against a row-count reference model.
// Build with +define+STATUS_FLUSH_EN to exercise the flush path.
module tb_status_init_ctrl;
    import status_init_ctrl_pkg::*;

    localparam int TW = 1;
`ifdef STATUS_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic                  gated_clk = 1'b0;
    logic                  arst_n;
    logic                  i_halt;
    logic [TW-1:0]         i_tag;
    logic [ADDR_WIDTH-1:0] i_r_addr;
    logic                  i_r_valid;
    logic                  o_r_ready;
    logic [ADDR_WIDTH-1:0] i_w_addr;
    logic [ROW_WIDTH-1:0]  i_w_data;
    logic [NUM_BLOCKS-1:0] i_w_wmask;
    logic                  i_w_valid;
    logic                  o_w_ready;
    logic                  i_flush;
    logic [TW-1:0]         o_tag;
    logic [ADDR_WIDTH-1:0] o_r_addr;
    logic                  o_r_valid;
    logic [ADDR_WIDTH-1:0] o_w_addr;
    logic [ROW_WIDTH-1:0]  o_w_data;
    logic [NUM_BLOCKS-1:0] o_w_wmask;
    logic                  o_w_valid;
    logic                  o_init_done;

    int total = 0;
    int bad   = 0;
    // Rows the current sweep has written so far; NUM_ROWS or more means RUN.
    int rows_done = 0;

    always #5 gated_clk = ~gated_clk;

    status_init_ctrl #(.TAG_WIDTH(TW)) dut (
        .gated_clk  (gated_clk),
        .arst_n     (arst_n),
        .i_halt     (i_halt),
        .i_tag      (i_tag),
        .i_r_addr   (i_r_addr),
        .i_r_valid  (i_r_valid),
        .o_r_ready  (o_r_ready),
        .i_w_addr   (i_w_addr),
        .i_w_data   (i_w_data),
        .i_w_wmask  (i_w_wmask),
        .i_w_valid  (i_w_valid),
        .o_w_ready  (o_w_ready),
`ifdef STATUS_FLUSH_EN
        .i_flush    (i_flush),
`endif
        .o_tag      (o_tag),
        .o_r_addr   (o_r_addr),
        .o_r_valid  (o_r_valid),
        .o_w_addr   (o_w_addr),
        .o_w_data   (o_w_data),
        .o_w_wmask  (o_w_wmask),
        .o_w_valid  (o_w_valid),
        .o_init_done(o_init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs from the current row count and the present inputs.
    task automatic check_model();
        bit running;
        bit clash;
        bit rd_ok;
        running = (rows_done >= NUM_ROWS);
        if (!running) begin
            chk("init_w_valid", 32'(o_w_valid), 32'(!i_halt));
            chk("init_w_addr",  32'(o_w_addr),  32'(rows_done % NUM_ROWS));
            chk("init_w_data",  32'(o_w_data),  32'd0);
            chk("init_w_mask",  32'(o_w_wmask), 32'hFF);
            chk("init_r_valid", 32'(o_r_valid), 32'd0);
            chk("init_r_ready", 32'(o_r_ready), 32'd0);
            chk("init_w_ready", 32'(o_w_ready), 32'd0);
            chk("init_tag",     32'(o_tag),     32'd0);
            chk("init_done",    32'(o_init_done), 32'd0);
        end else begin
            clash = i_w_valid && i_r_valid && (i_w_addr == i_r_addr);
            rd_ok = !i_halt && !clash;
            chk("run_w_ready", 32'(o_w_ready), 32'(!i_halt));
            chk("run_w_valid", 32'(o_w_valid), 32'(i_w_valid && !i_halt));
            chk("run_w_addr",  32'(o_w_addr),  32'(i_w_addr));
            chk("run_w_data",  32'(o_w_data),  32'(i_w_data));
            chk("run_w_mask",  32'(o_w_wmask), 32'(i_w_wmask));
            chk("run_r_ready", 32'(o_r_ready), 32'(rd_ok));
            chk("run_r_valid", 32'(o_r_valid), 32'(i_r_valid && rd_ok));
            chk("run_r_addr",  32'(o_r_addr),  32'(i_r_addr));
            chk("run_tag",     32'(o_tag),     (i_r_valid && rd_ok) ? 32'(i_tag) : 32'd0);
            chk("run_done",    32'(o_init_done), 32'd1);
        end
    endtask

    // One clock: check settled outputs, take the edge, advance the model.
    task automatic cycle();
        #1;
        check_model();
        @(posedge gated_clk);
        if (!arst_n) begin
            rows_done = 0;
        end else if (!i_halt) begin
            if (rows_done < NUM_ROWS) rows_done++;
            else if (FLUSH_EN && i_flush) rows_done = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        i_halt = 0; i_tag = '0; i_r_addr = '0; i_r_valid = 0;
        i_w_addr = '0; i_w_data = '0; i_w_wmask = '0; i_w_valid = 0; i_flush = 0;
    endtask

    task automatic rand_inputs(input bit allow_halt, input bit allow_flush);
        i_halt    = allow_halt && ($urandom_range(0, 7) == 0);
        i_tag     = TW'($urandom);
        i_r_addr  = ADDR_WIDTH'($urandom_range(0, 3));
        i_r_valid = 1'($urandom);
        i_w_addr  = ADDR_WIDTH'($urandom_range(0, 3));
        i_w_data  = ROW_WIDTH'($urandom);
        i_w_wmask = NUM_BLOCKS'($urandom);
        i_w_valid = 1'($urandom);
        i_flush   = allow_flush && ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        idle_inputs();
        arst_n = 0;
        #1;
        // Reset state: INIT decode with row 0.
        chk("rst_done",    32'(o_init_done), 32'd0);
        chk("rst_w_valid", 32'(o_w_valid),   32'd1);
        chk("rst_w_addr",  32'(o_w_addr),    32'd0);
        chk("rst_r_ready", 32'(o_r_ready),   32'd0);
        @(posedge gated_clk); #1;
        arst_n = 1;

        // Full sweep with reads presented: rows 0..15, reads refused.
        for (int i = 0; i < NUM_ROWS; i++) begin
            rand_inputs(1'b0, 1'b0);
            #1;
            chk("sweep_addr", 32'(o_w_addr), 32'(i));
            chk("sweep_r_ready", 32'(o_r_ready), 32'd0);
            cycle();
        end
        idle_inputs();
        #1;
        chk("sweep_done", 32'(o_init_done), 32'd1);

        // Conflict on row 3: write wins, read refused, then accepted.
        i_r_valid = 1; i_r_addr = 4'h3; i_tag = 1'b1;
        i_w_valid = 1; i_w_addr = 4'h3; i_w_data = 8'hA5; i_w_wmask = 8'h0F;
        #1;
        chk("cfl_w_valid", 32'(o_w_valid), 32'd1);
        chk("cfl_r_valid", 32'(o_r_valid), 32'd0);
        chk("cfl_r_ready", 32'(o_r_ready), 32'd0);
        cycle();
        i_w_valid = 0;
        #1;
        chk("retry_r_valid", 32'(o_r_valid), 32'd1);
        chk("retry_tag",     32'(o_tag),     32'd1);
        cycle();

        // Different rows in the same cycle: both forwarded.
        i_r_addr = 4'h2; i_w_addr = 4'h7; i_w_valid = 1;
        #1;
        chk("diff_r_ready", 32'(o_r_ready), 32'd1);
        chk("diff_w_ready", 32'(o_w_ready), 32'd1);
        chk("diff_r_valid", 32'(o_r_valid), 32'd1);
        chk("diff_w_valid", 32'(o_w_valid), 32'd1);
        cycle();

        // Reset mid-RUN: done drops immediately, sweep restarts with a halt at row 5.
        idle_inputs();
        arst_n = 0;
        rows_done = 0;
        #1;
        chk("arst_done", 32'(o_init_done), 32'd0);
        chk("arst_addr", 32'(o_w_addr),    32'd0);
        cycle();
        arst_n = 1;
        for (int i = 0; i < 5; i++) cycle();
        i_halt = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halt_addr",    32'(o_w_addr),  32'd5);
            chk("halt_w_valid", 32'(o_w_valid), 32'd0);
            cycle();
        end
        i_halt = 0;
        for (int i = 0; i < 11; i++) begin
            #1;
            chk("halt_sweep_done", 32'(o_init_done), 32'd0);
            cycle();
        end
        #1;
        chk("halt_done_c19", 32'(o_init_done), 32'd1);

`ifdef STATUS_FLUSH_EN
        // Flush with a same-cycle fill write: write forwarded, then full sweep.
        i_flush = 1; i_w_valid = 1; i_w_addr = 4'h9; i_w_data = 8'h3C; i_w_wmask = 8'h81;
        #1;
        chk("flush_w_valid", 32'(o_w_valid), 32'd1);
        chk("flush_w_addr",  32'(o_w_addr),  32'd9);
        cycle();
        idle_inputs();
        for (int i = 0; i < NUM_ROWS; i++) begin
            #1;
            chk("flush_sweep_addr", 32'(o_w_addr), 32'(i));
            chk("flush_sweep_data", 32'(o_w_data), 32'd0);
            cycle();
        end
        #1;
        chk("flush_done", 32'(o_init_done), 32'd1);
`endif

        // Random traffic with halts, occasional flushes and resets.
        for (int n = 0; n < 400; n++) begin
            rand_inputs(1'b1, FLUSH_EN);
            if ($urandom_range(0, 99) == 0) begin
                arst_n = 0;
                rows_done = 0;
            end else begin
                arst_n = 1;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/status_init_ctrl.md
Name: status_init_ctrl

Overview:
- Front-end controller directly upstream of the status array's read and write ports.
- After reset, and optionally on flush, it sweeps every status row and writes all-zero rows with a full mask, invalidating every block.
- While sweeping, fetch reads and fill writes are back-pressured.
- Once the sweep completes, it forwards fetch reads and fill writes to the array and resolves same-address read/write conflicts in favour of the write.

Parameters:
- TAG_WIDTH, 1, width of the request tag carried alongside reads.
- ADDR_WIDTH, 4, row address width; comes from shared_params.vh, not overridable here; NUM_ROWS = 2**ADDR_WIDTH.
- ROW_WIDTH, 8, status row width; from shared_params.vh.
- NUM_BLOCKS, 8, write-mask width; from shared_params.vh.

Ports:
- gated_clk  in  1  clock.
- arst_n  in  1  reset; asynchronous, active-low.
- i_halt  in  1  pipeline halt; freezes all state.
- i_tag  in  TAG_WIDTH  read request tag.
- i_r_addr  in  ADDR_WIDTH  read row address.
- i_r_valid  in  1  read request.
- o_r_ready  out  1  read accepted this cycle.
- i_w_addr  in  ADDR_WIDTH  fill write row address.
- i_w_data  in  ROW_WIDTH  fill write data.
- i_w_wmask  in  NUM_BLOCKS  fill block mask.
- i_w_valid  in  1  fill write request.
- o_w_ready  out  1  write accepted this cycle.
- i_flush  in  1  invalidate-all request; present only with STATUS_FLUSH_EN.
- o_tag, o_r_addr, o_r_valid  out  TAG_WIDTH/ADDR_WIDTH/1  to status array read port.
- o_w_addr, o_w_data, o_w_wmask, o_w_valid  out  ADDR_WIDTH/ROW_WIDTH/NUM_BLOCKS/1  to status array write port.
- o_init_done  out  1  high when in RUN.

Behaviour:
- State: FSM {INIT, RUN} plus an ADDR_WIDTH-bit sweep counter cnt. Reset value: state=INIT, cnt=0.
- Outputs are combinational decodes of state, cnt and inputs, with no added latency. Values during reset follow the INIT decode with cnt=0.
- INIT outputs:
  - o_w_valid=1, o_w_addr=cnt, o_w_data=0, o_w_wmask=all ones.
  - o_r_valid=0, o_tag=0, o_r_ready=0, o_w_ready=0, o_init_done=0.
- INIT transitions:
  - Each cycle with i_halt=0: cnt<=cnt+1 (wraps modulo NUM_ROWS).
  - When cnt==NUM_ROWS-1 and i_halt=0: state<=RUN, cnt wraps to 0.
  - Sweep takes exactly NUM_ROWS unhalted cycles.
- RUN outputs:
  - o_w_ready = ~i_halt.
  - o_w_valid = i_w_valid & ~i_halt; o_w_addr/data/wmask pass through.
  - conflict = i_w_valid & i_r_valid & (i_w_addr==i_r_addr).
  - o_r_ready = ~i_halt & ~conflict.
  - o_r_valid = i_r_valid & o_r_ready; o_r_addr passes through.
  - o_tag = i_tag & {TAG_WIDTH{o_r_valid}}.
  - o_init_done=1.
- Conflict handling: the read is refused for that cycle only. The requester holds the read and retries; it is accepted the next cycle unless the conflict persists.
- Halt: state and cnt frozen; all ready outputs 0; all valid outputs 0.
- Reset mid-RUN or mid-INIT: immediately returns to INIT with cnt=0 and a full sweep restarts.
- Read and write to different addresses in the same cycle: both forwarded.

Optional Feature:
- Macro: STATUS_FLUSH_EN.
- With it defined: i_flush port exists.
  - In RUN with i_flush=1 and i_halt=0: next state INIT, cnt=0.
  - A fill write presented in the same cycle as the flush is still forwarded, then wiped by the sweep.
  - i_flush is ignored during INIT, because writes are blocked and the sweep already covers every row.
- Without it: no i_flush port; RUN is terminal until reset.

Decomposition:
- shared_params.vh supplies ADDR_WIDTH, ROW_WIDTH, NUM_BLOCKS.
- Add to that file: localparams for FSM encodings ST_INIT=1'b0, ST_RUN=1'b1, and NUM_ROWS.
- No sub-module; the counter and FSM are small enough to stay inline.

Test Plan:
- Reset release, no halt (defaults): o_w_valid=1 with o_w_addr=0..15 on consecutive cycles, data=0, mask=8'hFF; o_init_done rises on cycle 16; o_r_ready=0 throughout the sweep.
- i_halt=1 for 3 cycles when cnt=5: o_w_addr holds at 5 and o_w_valid=0 during the halt; o_init_done rises on cycle 19.
- RUN, i_r_valid=1 and i_w_valid=1, both addr=4'h3: o_w_valid=1, o_r_valid=0, o_r_ready=0. Next cycle with no write: read forwarded, o_tag=i_tag.
- RUN, read addr=2 and write addr=7 in the same cycle: both forwarded; o_r_ready=1, o_w_ready=1.
- arst_n pulsed low mid-RUN: o_init_done=0 at once; sweep restarts at addr 0.
- STATUS_FLUSH_EN, i_flush=1 together with write addr=9: the write is forwarded that cycle; the next 16 cycles sweep addr 0..15 with zeros; o_init_done returns to 1.
